bus_master_if: RTL and testbench
================================

Name: bus_master_if

Overview:
- Master-side bus interface between a CPU pipeline memory stage and the shared bus.
- Directly consumes the selected-slave read data and ready that the bus slave multiplexer produces.
- Requests the bus from the arbiter, drives one address-strobe transfer, waits for the active-low ready, captures read data, and stalls the pipeline until the access completes.

Parameters:
- DATA_W, 32, word data width (matches the word data bus).
- ADDR_W, 30, word address width.
- TIMEOUT_CYC, 256, watchdog limit in cycles; used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- stall  in  1  pipeline stall; holds the completed result in this stage.
- flush  in  1  pipeline flush; suppresses starting a new access.
- req  in  1  memory access request from the pipeline.
- rw  in  1  1 = read, 0 = write.
- addr  in  ADDR_W  word address.
- wr_data  in  DATA_W  write data.
- rd_data  out  DATA_W  read result to the pipeline.
- busy  out  1  stall request to the pipeline.
- bus_req_  out  1  active-low bus request to the arbiter.
- bus_grnt_  in  1  active-low grant from the arbiter.
- bus_as_  out  1  active-low address strobe.
- bus_rw  out  1  bus read/write.
- bus_addr  out  ADDR_W  bus address.
- bus_wr_data  out  DATA_W  bus write data.
- bus_rd_data  in  DATA_W  read data from the slave multiplexer.
- bus_rdy_  in  1  active-low ready from the slave multiplexer.
- bus_err  out  1  timeout flag; only with BUS_TIMEOUT_EN.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - state = IDLE
  - bus_req_ = 1, bus_as_ = 1, bus_rw = 1 (read)
  - bus_addr = 0, bus_wr_data = 0, rd_data = 0
  - bus_err = 0
- Reset wins over every other condition, including mid-transfer. The bus is released in the same edge and no data is captured.
- busy is combinational:
  - IDLE: busy = req & ~flush.
  - REQ: busy = 1.
  - ACCESS: busy = bus_rdy_ (i.e. 1 while ready is high).
  - WAIT: busy = 0.
- States:
  - IDLE: if req & ~flush, then bus_req_ <= 0, latch addr/rw/wr_data into the bus_* registers, and go to REQ. Otherwise hold all bus_* outputs.
  - REQ: hold bus_req_ = 0. When bus_grnt_ == 0, set bus_as_ <= 0 for exactly one cycle and go to ACCESS.
  - ACCESS: bus_as_ <= 1.
    - If bus_rdy_ == 0: when rw = read, rd_data <= bus_rd_data; when rw = write, rd_data <= 0. Then bus_req_ <= 1, and go to WAIT if stall, else IDLE.
    - While bus_rdy_ == 1, remain in ACCESS holding bus_req_ = 0.
  - WAIT: hold rd_data. When ~stall, go to IDLE.
- Latency: minimum access is 3 cycles (request, grant-strobe, ready in the first ACCESS cycle).
- Flush behaviour:
  - A flush in REQ or ACCESS does not abort the transfer; the access completes and the bus is released normally.
  - A flush in IDLE blocks only the start of a new access.
- Ready timing: ready sampled in the same cycle as the strobe falls is ignored. Ready is sampled only in ACCESS.
- Grant loss: if grant is deasserted during ACCESS, the transfer still completes. Bus ownership hold-off is the arbiter's responsibility.
- No back-to-back issue: the state machine always passes through IDLE, so the next request starts no earlier than the cycle after IDLE is re-entered.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYC) clears on ACCESS entry and increments each cycle in ACCESS.
  - When it reaches TIMEOUT_CYC-1 without ready: rd_data <= 0, bus_err <= 1 for one cycle, bus_req_ <= 1, and the next state is IDLE or WAIT by the same stall rule as a normal completion.
  - If ready arrives on the terminal count cycle, normal completion wins and bus_err stays 0.
- Undefined: no counter, no bus_err port, and the block waits indefinitely for ready.

Decomposition:
- Shared bus header: add state encodings BUS_IF_STATE_IDLE/REQ/ACCESS/WAIT (2-bit) and the state bus width.
- Reuse the existing ENABLE_/DISABLE_, READ/WRITE and word data/address bus macros.
- No sub-module is needed; the timeout counter stays inline under the macro guard.

Test Plan:
- Read with 0 wait: req=1, rw=1, addr=0x100. Grant arrives the cycle after request; rdy_=0 with rd_data=0xDEADBEEF in the first ACCESS cycle. Expect rd_data=0xDEADBEEF, busy high for exactly 2 cycles, bus_as_ low for exactly 1 cycle.
- Write with 3 wait states: rw=0, wr_data=0x12345678. Expect bus_wr_data held at 0x12345678 through ACCESS, busy for 5 cycles, rd_data=0 after completion.
- Grant delay plus stall: grant withheld 4 cycles and stall=1 at completion. Expect state WAIT, rd_data held, bus_req_=1, and return to IDLE one cycle after stall falls.
- Flush: flush=1 together with req in IDLE, expect no bus_req_. Flush=1 in ACCESS, expect the transfer still completes.
- Reset mid-ACCESS: reset=1 while waiting for ready. Expect the next edge to give IDLE, bus_req_=1, bus_as_=1, rd_data=0.
- With BUS_TIMEOUT_EN and TIMEOUT_CYC=8: ready never asserted. Expect bus_err pulse, rd_data=0 and bus release after 8 ACCESS cycles; ready on cycle 8 gives a normal completion with bus_err=0.

Source files
------------

// File: rtl/bus_master_if_pkg.sv
// Shared bus definitions for bus_master_if: FSM state encodings, bus polarity
// constants and word widths.
package bus_master_if_pkg;

    localparam int BUS_IF_STATE_W = 2;

    typedef enum logic [BUS_IF_STATE_W-1:0] {
        BUS_IF_STATE_IDLE   = 2'd0,
        BUS_IF_STATE_REQ    = 2'd1,
        BUS_IF_STATE_ACCESS = 2'd2,
        BUS_IF_STATE_WAIT   = 2'd3
    } bus_if_state_e;

    // Active-low bus control levels
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Bus direction encoding
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int WORD_DATA_W = 32;
    localparam int WORD_ADDR_W = 30;

    // Pipeline stall request as a function of state and the live handshake inputs.
    function automatic logic bus_if_busy(input bus_if_state_e state,
                                         input logic          req,
                                         input logic          flush,
                                         input logic          rdy_n);
        logic busy;
        busy = 1'b0;
        case (state)
            BUS_IF_STATE_IDLE:   busy = req & ~flush;
            BUS_IF_STATE_REQ:    busy = 1'b1;
            BUS_IF_STATE_ACCESS: busy = rdy_n;
            BUS_IF_STATE_WAIT:   busy = 1'b0;
            default:             busy = 1'b0;
        endcase
        return busy;
    endfunction

endpackage

// File: rtl/bus_master_if.sv
// Master-side bus interface: request, strobe, wait for ready, capture, stall the pipeline.
// Optional BUS_TIMEOUT_EN adds an ACCESS watchdog and the bus_err output.
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int DATA_W      = WORD_DATA_W,
    parameter int ADDR_W      = WORD_ADDR_W,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
`ifdef BUS_TIMEOUT_EN
    output logic              bus_err,
`endif
    input  logic              bus_rdy_
);

    bus_if_state_e     r_state,       w_state_next;
    logic              r_bus_req_n,   w_bus_req_n_next;
    logic              r_bus_as_n,    w_bus_as_n_next;
    logic              r_bus_rw,      w_bus_rw_next;
    logic [ADDR_W-1:0] r_bus_addr,    w_bus_addr_next;
    logic [DATA_W-1:0] r_bus_wr_data, w_bus_wr_data_next;
    logic [DATA_W-1:0] r_rd_data,     w_rd_data_next;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] r_to_cnt, w_to_cnt_next;
    logic             r_bus_err, w_bus_err_next;
    logic             w_timeout;

    assign w_timeout = (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    // Without the watchdog the limit is irrelevant; it stays referenced so the
    // parameter list is identical in both builds.
    if (TIMEOUT_CYC < 1) begin : g_timeout_unused
    end
`endif

    always_comb begin
        w_state_next       = r_state;
        w_bus_req_n_next   = r_bus_req_n;
        w_bus_as_n_next    = r_bus_as_n;
        w_bus_rw_next      = r_bus_rw;
        w_bus_addr_next    = r_bus_addr;
        w_bus_wr_data_next = r_bus_wr_data;
        w_rd_data_next     = r_rd_data;
`ifdef BUS_TIMEOUT_EN
        w_to_cnt_next      = r_to_cnt;
        w_bus_err_next     = 1'b0;
`endif

        case (r_state)
            BUS_IF_STATE_IDLE: begin
                if (req && !flush) begin
                    w_bus_req_n_next   = ENABLE_;
                    w_bus_rw_next      = rw;
                    w_bus_addr_next    = addr;
                    w_bus_wr_data_next = wr_data;
                    w_state_next       = BUS_IF_STATE_REQ;
                end
            end

            BUS_IF_STATE_REQ: begin
                if (bus_grnt_ == ENABLE_) begin
                    w_bus_as_n_next = ENABLE_;
                    w_state_next    = BUS_IF_STATE_ACCESS;
`ifdef BUS_TIMEOUT_EN
                    w_to_cnt_next   = '0;
`endif
                end
            end

            BUS_IF_STATE_ACCESS: begin
                // Strobe is a single-cycle pulse; ready is only looked at from here on.
                w_bus_as_n_next = DISABLE_;
`ifdef BUS_TIMEOUT_EN
                w_to_cnt_next   = r_to_cnt + CNT_W'(1);
`endif
                if (bus_rdy_ == ENABLE_) begin
                    w_rd_data_next   = (r_bus_rw == READ) ? bus_rd_data : '0;
                    w_bus_req_n_next = DISABLE_;
                    w_state_next     = stall ? BUS_IF_STATE_WAIT : BUS_IF_STATE_IDLE;
                end
`ifdef BUS_TIMEOUT_EN
                else if (w_timeout) begin
                    w_rd_data_next   = '0;
                    w_bus_err_next   = 1'b1;
                    w_bus_req_n_next = DISABLE_;
                    w_state_next     = stall ? BUS_IF_STATE_WAIT : BUS_IF_STATE_IDLE;
                end
`endif
            end

            BUS_IF_STATE_WAIT: begin
                if (!stall) begin
                    w_state_next = BUS_IF_STATE_IDLE;
                end
            end

            default: begin
                w_state_next = BUS_IF_STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= BUS_IF_STATE_IDLE;
            r_bus_req_n   <= DISABLE_;
            r_bus_as_n    <= DISABLE_;
            r_bus_rw      <= READ;
            r_bus_addr    <= '0;
            r_bus_wr_data <= '0;
            r_rd_data     <= '0;
`ifdef BUS_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_bus_err     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_bus_req_n   <= w_bus_req_n_next;
            r_bus_as_n    <= w_bus_as_n_next;
            r_bus_rw      <= w_bus_rw_next;
            r_bus_addr    <= w_bus_addr_next;
            r_bus_wr_data <= w_bus_wr_data_next;
            r_rd_data     <= w_rd_data_next;
`ifdef BUS_TIMEOUT_EN
            r_to_cnt      <= w_to_cnt_next;
            r_bus_err     <= w_bus_err_next;
`endif
        end
    end

    assign busy        = bus_if_busy(r_state, req, flush, bus_rdy_);
    assign bus_req_    = r_bus_req_n;
    assign bus_as_     = r_bus_as_n;
    assign bus_rw      = r_bus_rw;
    assign bus_addr    = r_bus_addr;
    assign bus_wr_data = r_bus_wr_data;
    assign rd_data     = r_rd_data;
`ifdef BUS_TIMEOUT_EN
    assign bus_err     = r_bus_err;
`endif

endmodule

// File: tb/tb_bus_master_if.sv
// Directed-vector bench for bus_master_if; timeout steps run when BUS_TIMEOUT_EN is defined.
module tb_bus_master_if;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 30;

    logic              clk = 1'b0;
    logic              reset, stall, flush, req, rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data, rd_data, bus_wr_data, bus_rd_data;
    logic              busy, bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
    logic [ADDR_W-1:0] bus_addr;
`ifdef BUS_TIMEOUT_EN
    logic              bus_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .req(req), .rw(rw),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
`ifdef BUS_TIMEOUT_EN
        .bus_err(bus_err),
`endif
        .bus_rdy_(bus_rdy_)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%h expected=%h", n_vec, tag, obs, exp);
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; req = 1'b0; rw = 1'b1;
        addr = '0; wr_data = '0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_req_", bus_req_, 1);
        chk("rst_as_", bus_as_, 1);
        chk("rst_rw", bus_rw, 1);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wr_data, 0);
        chk("rst_rdata", rd_data, 0);
        chk("rst_busy", busy, 0);
`ifdef BUS_TIMEOUT_EN
        chk("rst_err", bus_err, 0);
`endif

        // Read, zero wait states
        tick();
        req = 1'b1; rw = 1'b1; addr = 30'h100;
        #1;
        chk("rd0_idle_busy", busy, 1);
        tick();
        chk("rd0_req_", bus_req_, 0);
        chk("rd0_addr", bus_addr, 32'h100);
        chk("rd0_req_as_", bus_as_, 1);
        chk("rd0_req_busy", busy, 1);
        bus_grnt_ = 1'b0;
        tick();
        chk("rd0_as_low", bus_as_, 0);
        bus_rdy_ = 1'b0; bus_rd_data = 32'hDEADBEEF; req = 1'b0;
        #1;
        chk("rd0_acc_busy", busy, 0);
        tick();
        chk("rd0_rdata", rd_data, 32'hDEADBEEF);
        chk("rd0_as_high", bus_as_, 1);
        chk("rd0_release", bus_req_, 1);
        chk("rd0_after_busy", busy, 0);
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;

        // Write, three wait states
        req = 1'b1; rw = 1'b0; addr = 30'h2A; wr_data = 32'h12345678;
        #1;
        chk("wr_idle_busy", busy, 1);
        tick();
        chk("wr_rw", bus_rw, 0);
        chk("wr_req_busy", busy, 1);
        bus_grnt_ = 1'b0;
        tick();
        chk("wr_as_low", bus_as_, 0);
        wr_data = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("wr_wait_busy", busy, 1);
            chk("wr_wdata_held", bus_wr_data, 32'h12345678);
            chk("wr_req_held", bus_req_, 0);
            tick();
        end
        chk("wr_as_pulse_once", bus_as_, 1);
        bus_rdy_ = 1'b0; bus_rd_data = 32'hFFFFFFFF; req = 1'b0;
        #1;
        chk("wr_rdy_busy", busy, 0);
        tick();
        chk("wr_rdata_zero", rd_data, 0);
        chk("wr_release", bus_req_, 1);
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;

        // Grant withheld four cycles, stall at completion
        req = 1'b1; rw = 1'b1; addr = 30'h3FF;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("gd_req_held", bus_req_, 0);
            chk("gd_no_strobe", bus_as_, 1);
            chk("gd_busy", busy, 1);
            tick();
        end
        bus_grnt_ = 1'b0;
        tick();
        chk("gd_as_low", bus_as_, 0);
        bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFEF00D; stall = 1'b1; req = 1'b0;
        tick();
        chk("gd_wait_rdata", rd_data, 32'hCAFEF00D);
        chk("gd_wait_release", bus_req_, 1);
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; bus_rd_data = 32'h11111111; req = 1'b1;
        #1;
        chk("gd_wait_busy", busy, 0);
        tick();
        chk("gd_wait_hold", rd_data, 32'hCAFEF00D);
        chk("gd_wait_no_req", bus_req_, 1);
        stall = 1'b0;
        tick();
        chk("gd_idle_busy", busy, 1);
        req = 1'b0;
        tick();
        chk("gd_idle_no_req", bus_req_, 1);
        chk("gd_idle_rdata", rd_data, 32'hCAFEF00D);
        bus_rd_data = '0;

        // Flush in IDLE blocks start; flush in ACCESS does not abort
        req = 1'b1; flush = 1'b1; rw = 1'b1; addr = 30'h55;
        #1;
        chk("fl_idle_busy", busy, 0);
        tick();
        chk("fl_idle_no_req", bus_req_, 1);
        flush = 1'b0;
        tick();
        chk("fl_req_", bus_req_, 0);
        bus_grnt_ = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        chk("fl_acc_busy", busy, 1);
        tick();
        chk("fl_acc_hold", bus_req_, 0);
        bus_rdy_ = 1'b0; bus_rd_data = 32'h0BADF00D; req = 1'b0;
        tick();
        chk("fl_done_rdata", rd_data, 32'h0BADF00D);
        chk("fl_done_release", bus_req_, 1);
        flush = 1'b0; bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; bus_rd_data = '0;

`ifdef BUS_TIMEOUT_EN
        // Ready never arrives: watchdog fires after 8 ACCESS cycles
        req = 1'b1; rw = 1'b1; addr = 30'h99;
        tick();
        bus_grnt_ = 1'b0;
        tick();
        req = 1'b0;
        for (int i = 1; i < 8; i++) begin
            chk("to_err_low", bus_err, 0);
            chk("to_busy", busy, 1);
            tick();
        end
        chk("to_last_busy", busy, 1);
        tick();
        chk("to_err_pulse", bus_err, 1);
        chk("to_rdata_zero", rd_data, 0);
        chk("to_release", bus_req_, 1);
        bus_grnt_ = 1'b1;
        tick();
        chk("to_err_clear", bus_err, 0);

        // Ready on the terminal-count cycle completes normally
        req = 1'b1; rw = 1'b1; addr = 30'hAA;
        tick();
        bus_grnt_ = 1'b0;
        tick();
        req = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        bus_rdy_ = 1'b0; bus_rd_data = 32'h600DCAFE;
        tick();
        chk("tc_rdata", rd_data, 32'h600DCAFE);
        chk("tc_no_err", bus_err, 0);
        chk("tc_release", bus_req_, 1);
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; bus_rd_data = '0;
`endif

        // Reset while waiting for ready
        req = 1'b1; rw = 1'b0; addr = 30'h77; wr_data = 32'hA5A5A5A5;
        tick();
        bus_grnt_ = 1'b0;
        tick();
        req = 1'b0;
        tick();
        chk("rs_acc_hold", bus_req_, 0);
        reset = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'hFFFFFFFF;
        tick();
        bus_rdy_ = 1'b1;
        #1;
        chk("rs_req_", bus_req_, 1);
        chk("rs_as_", bus_as_, 1);
        chk("rs_rdata", rd_data, 0);
        chk("rs_addr", bus_addr, 0);
        chk("rs_rw", bus_rw, 1);
        chk("rs_idle_busy", busy, 0);
        reset = 1'b0; bus_grnt_ = 1'b1; bus_rd_data = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
